// File: rtl/bin2bcd_pkg.sv
// Shared types, constants and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Per-digit offset applied when excess-3 output coding is selected.
  localparam logic [3:0] XS3_OFFSET = 4'd3;

  // Decimal digits needed to represent 2^width-1 (at least 1).
  function automatic int unsigned bcd_digits_for(input int unsigned width);
    longint unsigned v;
    int unsigned     n;
    v = (width >= 64) ? '1 : ((64'(1) << width) - 64'(1));
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake and data bundle between a producer/consumer (master) and bin2bcd_seq (slave).
interface bin2bcd_seq_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);

  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_ovf;

  modport master (
    output in_valid,
    output in_bin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bcd,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_bin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bcd,
    output out_ovf
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Pre-shift correction so the following doubling carries into the next digit.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// valid/ready handshakes on both sides. Result is held until the consumer takes it.
// Optional macro BIN2BCD_XS3_OUT_EN: output digits in excess-3 code instead of BCD.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic             clk,
  input logic             rst_n,
  bin2bcd_seq_if.slave    bus
);

  localparam int unsigned CntW        = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int unsigned DigW        = 4 * DIGITS;
  // Overflow can only happen when the digit register is narrower than the full range.
  localparam bit          OvfPossible = (DIGITS < bcd_digits_for(BIN_W));

  if (BIN_W < 1) begin : g_bad_bin_w
    $error("bin2bcd_seq: BIN_W must be >= 1");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS must be >= 1");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [DigW-1:0]   dig_q, dig_d;
  logic              ovf_q, ovf_d;
  logic [DigW-1:0]   bcd_q, bcd_d;
  logic              res_ovf_q, res_ovf_d;

  logic [DigW-1:0]   dig_adj;
  logic [DigW-1:0]   dig_shift;
  logic [DigW-1:0]   dig_out;
  logic              carry;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (dig_q[4*d +: 4]),
      .digit_o (dig_adj[4*d +: 4])
    );
  end

  // Adjusted digits shift left, taking the next binary MSB into the bottom digit.
  assign dig_shift = {dig_adj[DigW-2:0], bin_q[BIN_W-1]};
  assign carry     = dig_adj[DigW-1];

  // Output coding applied as the final result is captured.
  always_comb begin
    dig_out = dig_shift;
`ifdef BIN2BCD_XS3_OUT_EN
    for (int d = 0; d < int'(DIGITS); d++) begin
      dig_out[4*d +: 4] = dig_shift[4*d +: 4] + XS3_OFFSET;
    end
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    dig_d     = dig_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    res_ovf_d = res_ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StShift;
          bin_d   = bus.in_bin;
          dig_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        dig_d = dig_shift;
        bin_d = bin_q << 1;
        ovf_d = ovf_q | (OvfPossible & carry);
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(BIN_W - 1)) begin
          state_d   = StDone;
          cnt_d     = '0;
          bcd_d     = dig_out;
          res_ovf_d = ovf_d;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bin_q     <= '0;
      dig_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      dig_q     <= dig_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_bcd   = bcd_q;
  assign bus.out_ovf   = res_ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a full-range instance (8 bits, 3 digits) and an
// overflow instance (8 bits, 2 digits). Follows BIN2BCD_XS3_OUT_EN for expected coding.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(8), .DIGITS(bcd_digits_for(8))) ia ();
  bin2bcd_seq_if #(.BIN_W(8), .DIGITS(2)) ib ();

  bin2bcd_seq #(.BIN_W(8), .DIGITS(bcd_digits_for(8))) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Expected output coding of a packed BCD value.
  function automatic logic [11:0] enc(input logic [11:0] b);
    logic [11:0] r;
    r = b;
`ifdef BIN2BCD_XS3_OUT_EN
    for (int i = 0; i < 3; i++) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
`endif
    return r;
  endfunction

  function automatic logic [11:0] model3(input int v);
    logic [11:0] r;
    r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    return enc(r);
  endfunction

  // Monitor A: latency on rise, stability while held, value on handshake.
  logic        va_p = 1'b0;
  logic [11:0] pa_bcd;
  logic        pa_ovf;
  always @(negedge clk) begin
    if (!rst_n) begin
      va_p = 1'b0;
    end else begin
      if (ia.out_valid) begin
        if (!va_p) begin
          chk("a_result_expected", 32'(qa.size() != 0), 32'd1);
          if (qa.size() != 0) chk("a_latency", cyc, qa[0].acc + 8);
        end else begin
          chk("a_stable_bcd", ia.out_bcd, pa_bcd);
          chk("a_stable_ovf", ia.out_ovf, pa_ovf);
        end
        if (ia.out_ready && qa.size() != 0) begin
          ea = qa.pop_front();
          chk("a_bcd", ia.out_bcd, ea.bcd);
          chk("a_ovf", ia.out_ovf, ea.ovf);
        end
      end
      va_p   = ia.out_valid;
      pa_bcd = ia.out_bcd;
      pa_ovf = ia.out_ovf;
    end
  end

  // Monitor B: two-digit instance.
  logic vb_p = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      vb_p = 1'b0;
    end else begin
      if (ib.out_valid) begin
        if (!vb_p) begin
          chk("b_result_expected", 32'(qb.size() != 0), 32'd1);
          if (qb.size() != 0) chk("b_latency", cyc, qb[0].acc + 8);
        end
        if (ib.out_ready && qb.size() != 0) begin
          eb = qb.pop_front();
          chk("b_bcd", ib.out_bcd, eb.bcd[7:0]);
          chk("b_ovf", ib.out_ovf, eb.ovf);
        end
      end
      vb_p = ib.out_valid;
    end
  end

  task automatic send_a(input logic [7:0] v, input logic [11:0] bcd, input logic ovf);
    int n = 0;
    while (!ia.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ia.in_ready) chk("a_in_ready_timeout", ia.in_ready, 1);
    ia.in_valid = 1'b1;
    ia.in_bin   = v;
    qa.push_back('{bcd: bcd, ovf: ovf, acc: cyc + 1});
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    ia.in_bin   = 8'hA5;
  endtask

  task automatic send_b(input logic [7:0] v, input logic [11:0] bcd, input logic ovf);
    int n = 0;
    while (!ib.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ib.in_ready) chk("b_in_ready_timeout", ib.in_ready, 1);
    ib.in_valid = 1'b1;
    ib.in_bin   = v;
    qb.push_back('{bcd: bcd, ovf: ovf, acc: cyc + 1});
    @(posedge clk); #1;
    ib.in_valid = 1'b0;
    ib.in_bin   = 8'h5A;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", qa.size() + qb.size(), 0);
  endtask

  initial begin
    ia.in_valid = 1'b0; ia.in_bin = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_bin = '0; ib.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ia.in_ready, 1);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_out_bcd", ia.out_bcd, 0);
    chk("rst_out_ovf", ia.out_ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed values.
    send_a(8'd255, enc(12'h255), 1'b0);
    send_a(8'd0,   enc(12'h000), 1'b0);
    send_a(8'd99,  enc(12'h099), 1'b0);
    send_a(8'd100, enc(12'h100), 1'b0);
    send_a(8'd9,   enc(12'h009), 1'b0);
    drain();

    // Exhaustive sweep.
    for (int v = 0; v < 256; v++) send_a(8'(v), model3(v), 1'b0);
    drain();

    // Back-pressure: result held, input ignored, single handshake on release.
    ia.out_ready = 1'b0;
    send_a(8'd123, enc(12'h123), 1'b0);
    for (int n = 0; n < 30 && !ia.out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_seen", ia.out_valid, 1);
    ia.in_valid = 1'b1;
    ia.in_bin   = 8'd7;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", ia.in_ready, 0);
      chk("bp_out_valid", ia.out_valid, 1);
    end
    @(posedge clk); #1;
    ia.in_valid  = 1'b0;
    ia.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", ia.in_ready, 1);
    chk("bp_release_out_valid", ia.out_valid, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("bp_no_extra_accept", ia.in_ready, 1);

    // Reset while cnt == 4 aborts the conversion.
    send_a(8'd200, enc(12'h200), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    qa.delete();
    #1;
    chk("midrst_out_valid", ia.out_valid, 0);
    chk("midrst_out_bcd", ia.out_bcd, 0);
    chk("midrst_in_ready", ia.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_a(8'd37, enc(12'h037), 1'b0);
    drain();

    // Two-digit instance: overflow keeps value mod 100.
    send_b(8'd200, enc(12'h000), 1'b1);
    send_b(8'd99,  enc(12'h099), 1'b0);
    send_b(8'd255, enc(12'h055), 1'b1);
    send_b(8'd100, enc(12'h000), 1'b1);
    send_b(8'd42,  enc(12'h042), 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
